regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between NUM_REQ write-back requesters
//  (e.g. ALU, load unit, multi-cycle mul/div). Arbitration is round-robin.

---
 rtl/regfile_write_arbiter_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants, also used by the register file and issue logic.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: starting at ptr and ascending modulo N, the first
// asserted request wins. Produces a one-hot grant plus the encoded winner.
// Kept generic so the memory-port sharing logic can reuse it.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [PTR_W-1:0] cand;

  // Rotating priority search; the first hit after ptr takes the grant.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ write-back
// sources with round-robin arbitration, drives the write port from a
// registered stage, and keeps a pending-write scoreboard for the issue logic.
//
// Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i]
// at the rising clock edge; req_ready is combinational and depends on req_valid,
// and a requester that is not granted must hold its addr/data stable until it is.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       write_reg,
  output logic [DATA_W-1:0]       write_data,
  output logic [2**ADDR_W-1:0]    busy_mask
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Grants only go to valid requesters, so a grant is itself a transfer.
  assign req_ready = grant;

  // One-hot mux of the winner's address and data.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer and output-stage contents; writes to register 0 are accepted but dropped.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (win_addr != ZERO_ADDR) begin
        reg_write_d  = 1'b1;
        write_reg_d  = win_addr;
        write_data_d = win_data;
      end
    end
  end

  // Scoreboard: commits clear, reservations set, and a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != ZERO_ADDR)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset discards any accepted but uncommitted write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy_mask  = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clock;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         write_reg;
  logic [DATA_W-1:0]         write_data;
  logic [2**ADDR_W-1:0]      busy_mask;

  int n_vec = 0;
  int n_err = 0;

  // Expected commits: {addr, data} in grant order.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  regfile_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .busy_mask  (busy_mask)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                 = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Compare the registered write port against the next expected commit.
  task automatic check_commit(input string tag);
    logic [ADDR_W+DATA_W-1:0] e;
    check({tag, "_we"}, 64'(RegWrite), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_reg"}, 64'(write_reg), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
      check({tag, "_data"}, 64'(write_data), 64'(e[DATA_W-1:0]));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    tick();
    tick();
    check("rst_we", 64'(RegWrite), 64'd0);
    check("rst_reg", 64'(write_reg), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single write from requester 0.
    set_req(0, 1'b1, 5'd1, 32'h11);
    #1;
    check("single_ready", 64'(req_ready), 64'b01);
    exp_q.push_back({5'd1, 32'h11});
    tick();
    check_commit("single");

    // Requester 1 targets register 0 while the pointer sits at 1.
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd0, 32'hFFFF);
    #1;
    check("zero_ready", 64'(req_ready), 64'b10);
    tick();
    check("zero_we", 64'(RegWrite), 64'd0);

    // Contention: pointer advanced to 0, so requester 0 goes first.
    set_req(0, 1'b1, 5'd21, 32'd17);
    set_req(1, 1'b1, 5'd22, 32'd29);
    #1;
    check("cont_ready0", 64'(req_ready), 64'b01);
    exp_q.push_back({5'd21, 32'd17});
    tick();
    check_commit("cont_first");
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("cont_ready1", 64'(req_ready), 64'b10);
    exp_q.push_back({5'd22, 32'd29});
    tick();
    check_commit("cont_second");
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();
    check("cont_idle_we", 64'(RegWrite), 64'd0);

    // Fairness: both valid for six cycles, grants alternate starting at 0.
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b1, 5'(10 + k), 32'h100 + 32'(k));
      set_req(1, 1'b1, 5'(20 + k), 32'h200 + 32'(k));
      #1;
      if (k % 2 == 0) begin
        check("fair_ready", 64'(req_ready), 64'b01);
        exp_q.push_back({5'(10 + k), 32'h100 + 32'(k)});
      end else begin
        check("fair_ready", 64'(req_ready), 64'b10);
        exp_q.push_back({5'(20 + k), 32'h200 + 32'(k)});
      end
      tick();
      check_commit("fair");
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);

    // Scoreboard: reserve, commit clears, same-cycle reserve wins.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    tick();
    rsv_valid = 1'b0;
    check("sb_set", 64'(busy_mask), 64'h20);
    set_req(0, 1'b1, 5'd5, 32'h55);
    exp_q.push_back({5'd5, 32'h55});
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check_commit("sb_write");
    check("sb_busy_during_commit", 64'(busy_mask), 64'h20);
    tick();
    check("sb_cleared", 64'(busy_mask), 64'h0);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    tick();
    rsv_valid = 1'b0;
    set_req(0, 1'b1, 5'd5, 32'h56);
    exp_q.push_back({5'd5, 32'h56});
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check_commit("sb_rewrite");
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    tick();
    check("sb_set_wins", 64'(busy_mask), 64'h20);
    rsv_addr = 5'd0;
    tick();
    rsv_valid = 1'b0;
    check("sb_zero_rsv", 64'(busy_mask), 64'h20);

    // Asynchronous reset mid-operation with a write in flight.
    set_req(0, 1'b1, 5'd7, 32'h77);
    exp_q.push_back({5'd7, 32'h77});
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check_commit("pre_rst");
    check("pre_rst_busy", 64'(busy_mask), 64'h20);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_we", 64'(RegWrite), 64'd0);
    check("async_rst_reg", 64'(write_reg), 64'd0);
    check("async_rst_data", 64'(write_data), 64'd0);
    check("async_rst_busy", 64'(busy_mask), 64'd0);
    tick();
    reset_n = 1'b1;

    // Pointer was at 1 before reset; it must restart at 0.
    set_req(0, 1'b1, 5'd3, 32'h33);
    set_req(1, 1'b1, 5'd4, 32'h44);
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b01);
    exp_q.push_back({5'd3, 32'h33});
    tick();
    check_commit("post_rst");
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
